// File: rtl/capture_rect_if.sv
// vga_if: one VGA pixel-stream beat (timing counters, sync, blanking, RGB 4:4:4).
interface vga_if;
   logic [11:0] hcount;
   logic [11:0] vcount;
   logic        hsync;
   logic        vsync;
   logic        hblnk;
   logic        vblnk;
   logic [11:0] rgb;

   modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
   modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/capture_rect.sv
// capture_rect: grabs a WxH window of a VGA stream into image memory, one frame per start.
// Optional macro CAPTURE_OUTLINE_EN draws a COLOR ring around the window while busy.
module capture_rect #(
   parameter int          W     = 48,
   parameter int          H     = 64,
   parameter logic [11:0] COLOR = 12'hF00
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [11:0] x,
   input  logic [11:0] y,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic        wr_en,
   output logic [11:0] wr_addr,
   output logic [11:0] wr_data,
   vga_if.in           vga_in,
   vga_if.out          vga_out
);

   typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, FINISH} state_t;

   state_t      state;
   logic [11:0] xl, yl;

   // 13-bit window bounds so x+W / y+H never wrap
   logic [12:0] hc13, vc13, xl13, yl13, x_end, y_end;
   logic        visible, in_win, is_last, origin, sample, outline;
   logic [5:0]  row, col;

   assign hc13  = {1'b0, vga_in.hcount};
   assign vc13  = {1'b0, vga_in.vcount};
   assign xl13  = {1'b0, xl};
   assign yl13  = {1'b0, yl};
   assign x_end = xl13 + 13'(W);
   assign y_end = yl13 + 13'(H);

   assign visible = !vga_in.hblnk && !vga_in.vblnk;
   assign in_win  = visible && (hc13 >= xl13) && (hc13 < x_end) &&
                    (vc13 >= yl13) && (vc13 < y_end);
   assign is_last = in_win && (hc13 == x_end - 13'd1) && (vc13 == y_end - 13'd1);
   assign origin  = (vga_in.hcount == 12'd0) && (vga_in.vcount == 12'd0);

   // ARMED evaluates the origin pixel itself; in CAPTURE the origin means the frame wrapped
   assign sample = ((state == ARMED) && origin) || ((state == CAPTURE) && !origin);

   assign row = vga_in.vcount[5:0] - yl[5:0];
   assign col = vga_in.hcount[5:0] - xl[5:0];

`ifdef CAPTURE_OUTLINE_EN
   logic [12:0] hp1, vp1;
   logic        span, ring;
   assign hp1  = hc13 + 13'd1;
   assign vp1  = vc13 + 13'd1;
   assign span = (hp1 >= xl13) && (hc13 <= x_end) && (vp1 >= yl13) && (vc13 <= y_end);
   assign ring = (hp1 == xl13) || (hc13 == x_end) || (vp1 == yl13) || (vc13 == y_end);
   assign outline = busy && visible && span && ring;
`else
   assign outline = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         xl             <= '0;
         yl             <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         wr_en          <= 1'b0;
         wr_addr        <= '0;
         wr_data        <= '0;
         vga_out.hcount <= '0;
         vga_out.vcount <= '0;
         vga_out.hsync  <= 1'b0;
         vga_out.vsync  <= 1'b0;
         vga_out.hblnk  <= 1'b0;
         vga_out.vblnk  <= 1'b0;
         vga_out.rgb    <= '0;
      end else begin
         vga_out.hcount <= vga_in.hcount;
         vga_out.vcount <= vga_in.vcount;
         vga_out.hsync  <= vga_in.hsync;
         vga_out.vsync  <= vga_in.vsync;
         vga_out.hblnk  <= vga_in.hblnk;
         vga_out.vblnk  <= vga_in.vblnk;
         vga_out.rgb    <= outline ? COLOR : vga_in.rgb;

         done  <= 1'b0;
         wr_en <= 1'b0;
         if (sample && in_win) begin
            wr_en   <= 1'b1;
            wr_addr <= {row, col};
            wr_data <= vga_in.rgb;
         end

         case (state)
            IDLE: begin
               // done is still high on the cycle after FINISH; a start there is dropped
               if (start && !done) begin
                  xl    <= x;
                  yl    <= y;
                  busy  <= 1'b1;
                  state <= ARMED;
               end
            end
            ARMED: begin
               if (origin) state <= is_last ? FINISH : CAPTURE;
            end
            CAPTURE: begin
               if (origin || is_last) state <= FINISH;
            end
            FINISH: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_capture_rect.sv
// tb_capture_rect: drives a small raster, predicts window writes from the window geometry.
`timescale 1ns/1ps
module tb_capture_rect;
   localparam int W = 24, H = 16;
   localparam int HV = 64, HT = 70, VV = 40, VT = 42;
   localparam int FRAME = HT * VT;
   localparam logic [11:0] COLOR = 12'h0A5;

   logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
   logic [11:0] x = '0, y = '0;
   logic        busy, done, wr_en;
   logic [11:0] wr_addr, wr_data;

   vga_if vin();
   vga_if vout();

   capture_rect #(.W(W), .H(H), .COLOR(COLOR)) dut (
      .clk(clk), .rst(rst), .x(x), .y(y), .start(start),
      .busy(busy), .done(done), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .vga_in(vin), .vga_out(vout));

   always #5 clk = ~clk;

   int          hc = 0, vc = 0;
   int          nasrt = 0, nfail = 0;
   bit          grad = 1'b0;
   logic [11:0] seed = '0;
   logic [23:0] got[$];
   logic [23:0] expq[$];
   int          done_cnt = 0;
   bit          wr_before_done = 1'b0, busy_at_done = 1'b0, last_wr = 1'b0;
   bit          tb_busy = 1'b0;
   int          wx = 0, wy = 0;

   function automatic logic [11:0] pix(int h, int v);
      return grad ? 12'(h) : 12'(h * 37 + v * 101 + int'(seed));
   endfunction

`ifdef CAPTURE_OUTLINE_EN
   function automatic bit on_ring(int h, int v);
      return h >= wx - 1 && h <= wx + W && v >= wy - 1 && v <= wy + H &&
             (h == wx - 1 || h == wx + W || v == wy - 1 || v == wy + H) && h < HV && v < VV;
   endfunction
`endif

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nasrt++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive();
      vin.hcount = 12'(hc);
      vin.vcount = 12'(vc);
      vin.hblnk  = (hc >= HV);
      vin.vblnk  = (vc >= VV);
      vin.hsync  = (hc >= HV + 2) && (hc < HV + 4);
      vin.vsync  = (vc == VV + 1);
      vin.rgb    = pix(hc, vc);
   endtask

   // one clock: sample outputs #1 after the edge, then advance the raster
   task automatic step();
      logic [40:0] cur, obs;
      bit          rst_at, bb;
      int          ph, pv;
      cur    = {vin.hcount, vin.vcount, vin.hsync, vin.vsync, vin.hblnk, vin.vblnk, vin.rgb};
      rst_at = rst;
      bb     = tb_busy;
      ph     = hc;
      pv     = vc;
      @(posedge clk);
      #1;
      obs = {vout.hcount, vout.vcount, vout.hsync, vout.vsync, vout.hblnk, vout.vblnk, vout.rgb};
      if (!rst_at) begin
`ifdef CAPTURE_OUTLINE_EN
         if (bb && on_ring(ph, pv)) cur[11:0] = COLOR;
`else
         if (bb && ph < 0 && pv < 0) cur[11:0] = COLOR;
`endif
         chk("vga_passthru", 64'(obs), 64'(cur));
      end
      if (wr_en) got.push_back({wr_addr, wr_data});
      if (done) begin
         done_cnt++;
         busy_at_done   = busy;
         wr_before_done = last_wr;
         tb_busy        = 1'b0;
      end
      last_wr = wr_en;
      hc++;
      if (hc == HT) begin
         hc = 0;
         vc++;
         if (vc == VT) vc = 0;
      end
      drive();
   endtask

   task automatic begin_cap(input int nx, input int ny);
      x = 12'(nx);
      y = 12'(ny);
      wx = nx;
      wy = ny;
      got.delete();
      expq.delete();
      done_cnt = 0;
      for (int r = ny; r < ny + H; r++)
         for (int c = nx; c < nx + W; c++)
            if (c < HV && r < VV) expq.push_back({6'(r - ny), 6'(c - nx), pix(c, r)});
      start = 1'b1;
      step();
      start = 1'b0;
      tb_busy = 1'b1;
      chk("busy_after_start", 64'(busy), 64'(1));
   endtask

   task automatic finish_cap(input bit noise, input bit chain);
      int n = 0;
      int m;
      while (done_cnt == 0 && n < 3 * FRAME) begin
         if (noise) begin
            start = ($urandom_range(0, 15) == 0);
            x = 12'($urandom);
            y = 12'($urandom);
         end
         step();
         n++;
      end
      start = 1'b0;
      chk("done_seen", 64'(done_cnt), 64'(1));
      chk("busy_low_at_done", 64'(busy_at_done), 64'(0));
      chk("write_count", 64'(got.size()), 64'(expq.size()));
      m = (got.size() < expq.size()) ? got.size() : expq.size();
      for (int i = 0; i < m; i++) chk("write_addr_data", 64'(got[i]), 64'(expq[i]));
      if (expq.size() > 0 && wx + W - 1 < HV && wy + H - 1 < VV)
         chk("last_write_before_done", 64'(wr_before_done), 64'(1));
      if (chain) begin
         start = 1'b1;
         step();
         chk("start_on_done_ignored", 64'(busy), 64'(0));
      end else begin
         m = got.size();
         for (int i = 0; i < 3; i++) step();
         chk("single_done_pulse", 64'(done_cnt), 64'(1));
         chk("no_late_writes", 64'(got.size()), 64'(m));
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_busy"}, 64'(busy), 64'(0));
      chk({tag, "_done"}, 64'(done), 64'(0));
      chk({tag, "_wr_en"}, 64'(wr_en), 64'(0));
      chk({tag, "_wr_addr"}, 64'(wr_addr), 64'(0));
      chk({tag, "_wr_data"}, 64'(wr_data), 64'(0));
      chk({tag, "_vga_out"}, 64'({vout.hcount, vout.vcount, vout.hsync, vout.vsync,
                                   vout.hblnk, vout.vblnk, vout.rgb}), 64'(0));
   endtask

   initial begin
      int n;
      drive();
      rst = 1'b1;
      for (int i = 0; i < 3; i++) step();
      chk_zero("reset");
      rst = 1'b0;
      for (int i = 0; i < 50; i++) step();
      chk("idle_busy", 64'(busy), 64'(0));
      chk("idle_no_writes", 64'(got.size()), 64'(0));

      // gradient: data must equal 20 + col
      grad = 1'b1;
      begin_cap(20, 10);
      finish_cap(1'b0, 1'b0);

      // origin-aligned window, x/y/start toggled while busy
      grad = 1'b0;
      seed = 12'($urandom);
      begin_cap(0, 0);
      finish_cap(1'b1, 1'b0);

      // clipped by blanking: 12 cols x 8 rows, done at next origin
      begin_cap(52, 32);
      finish_cap(1'b0, 1'b0);
      chk("clipped_count", 64'(got.size()), 64'(96));

      // start on done cycle ignored, next cycle accepted
      begin_cap(5, 20);
      finish_cap(1'b0, 1'b1);
      begin_cap(30, 3);
      finish_cap(1'b0, 1'b0);

      // reset mid-capture
      begin_cap(10, 5);
      n = 0;
      while (got.size() < 10 && n < 3 * FRAME) begin
         step();
         n++;
      end
      chk("mid_capture_reached", 64'(got.size() >= 10), 64'(1));
      rst = 1'b1;
      tb_busy = 1'b0;
      step();
      chk_zero("mid_reset");
      rst = 1'b0;
      got.delete();
      done_cnt = 0;
      for (int i = 0; i < FRAME + 5 * HT; i++) step();
      chk("post_reset_no_writes", 64'(got.size()), 64'(0));
      chk("post_reset_no_done", 64'(done_cnt), 64'(0));
      chk("post_reset_idle", 64'(busy), 64'(0));

      // random windows and pixel data
      for (int k = 0; k < 2; k++) begin
         seed = 12'($urandom);
         begin_cap(int'($urandom_range(0, 70)), int'($urandom_range(0, 45)));
         finish_cap(1'b1, 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nasrt, nfail);
      $finish;
   end
endmodule
